// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the SDRAM request arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int PRIO_CNT_W = 4;
    localparam int WDOG_W     = 10;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Rotating-priority encoder: first set REQ bit at or above rr_ptr, wrapping.
module ram_arb_rr_pick
    import ram_arb_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic [COUNT-1:0]         REQ,
    input  logic [$clog2(COUNT)-1:0] rr_ptr,
    output logic                     VALID,
    output logic [$clog2(COUNT)-1:0] IDX
);
    localparam int IW = $clog2(COUNT);

    logic [IW-1:0] k;

    always_comb begin
        VALID = 1'b0;
        IDX   = '0;
        k     = (rr_ptr > IW'(COUNT - 1)) ? '0 : rr_ptr;
        for (int j = 0; j < COUNT; j++) begin
            if (REQ[k] && !VALID) begin
                VALID = 1'b1;
                IDX   = k;
            end
            k = IW'(wrap_inc(32'(k), 32'(COUNT)));
        end
    end

endmodule

// File: rtl/ram_req_arbiter.sv
// Shares one SDRAM request port among COUNT clients: requester-0 priority with a
// burst limit, round-robin for the rest, and a watchdog so no client hangs.
module ram_req_arbiter
    import ram_arb_pkg::*;
#(
    parameter int COUNT      = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 16,
    parameter int PRIO0      = 1,
    parameter int PRIO_LIMIT = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [COUNT-1:0]                   REQ,
    input  logic [COUNT-1:0][ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [COUNT-1:0]                   REQ_WE,
    input  logic [COUNT-1:0][DATA_WIDTH-1:0]   REQ_DIN,
    input  logic [COUNT-1:0][DATA_WIDTH/8-1:0] REQ_BE,
    output logic [COUNT-1:0]                   ACK,
    output logic                               ERR,
    output logic [DATA_WIDTH-1:0]              DOUT,
    output logic                               MEM_REQ,
    output logic [ADDR_WIDTH-1:0]              MEM_ADDR,
    output logic                               MEM_WE,
    output logic [DATA_WIDTH-1:0]              MEM_DIN,
    output logic [DATA_WIDTH/8-1:0]            MEM_BE,
    input  logic                               MEM_ACK,
    input  logic [DATA_WIDTH-1:0]              MEM_DOUT,
    output logic                               BUSY,
    output logic [$clog2(COUNT)-1:0]           GRANT
);
    localparam int GW = $clog2(COUNT);
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [GW-1:0] RR_INIT = (PRIO0 != 0) ? GW'(1) : GW'(0);

    arb_state_t              state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
    logic [BW-1:0]           mem_be_q, mem_be_d;
    logic [COUNT-1:0]        ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    busy_q, busy_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           rr_q, rr_d;
    logic [PRIO_CNT_W-1:0]   pcnt_q, pcnt_d;
    logic [WDOG_W-1:0]       wdog_q, wdog_d;

    logic             others;
    logic             prio_win;
    logic             launch;
    logic [COUNT-1:0] rr_mask;
    logic             rr_valid;
    logic [GW-1:0]    rr_idx;
    logic [GW-1:0]    rr_next;
    logic [GW-1:0]    sel;

    assign others   = |REQ[COUNT-1:1];
    assign prio_win = (PRIO0 != 0) && REQ[0] &&
                      ((pcnt_q < PRIO_CNT_W'(PRIO_LIMIT)) || !others);
    assign launch   = prio_win || rr_valid;
    assign sel      = prio_win ? '0 : rr_idx;

    // With the override enabled requester 0 never wins through round-robin.
    always_comb begin
        rr_mask = REQ;
        if (PRIO0 != 0) rr_mask[0] = 1'b0;
    end

    always_comb begin
        rr_next = GW'(wrap_inc(32'(rr_idx), 32'(COUNT)));
        if (PRIO0 != 0 && rr_next == '0) rr_next = GW'(1);
    end

    ram_arb_rr_pick #(.COUNT(COUNT)) u_pick (
        .REQ    (rr_mask),
        .rr_ptr (rr_q),
        .VALID  (rr_valid),
        .IDX    (rr_idx)
    );

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        mem_din_d  = mem_din_q;
        mem_be_d   = mem_be_q;
        ack_d      = '0;
        err_d      = err_q;
        dout_d     = dout_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        pcnt_d     = pcnt_q;
        wdog_d     = wdog_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = REQ_ADDR[sel];
                    mem_we_d   = REQ_WE[sel];
                    mem_din_d  = REQ_DIN[sel];
                    mem_be_d   = REQ_BE[sel];
                    grant_d    = sel;
                    wdog_d     = '0;
                    if (prio_win) begin
                        pcnt_d = others ? pcnt_q + PRIO_CNT_W'(1) : '0;
                    end else begin
                        pcnt_d = '0;
                        rr_d   = rr_next;
                    end
                end
            end
            WAIT: begin
                // A memory ack in the expiry cycle still delivers real data.
                if (MEM_ACK) begin
                    state_d        = DONE;
                    mem_req_d      = 1'b0;
                    dout_d         = MEM_DOUT;
                    err_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                end else if (wdog_q == WDOG_W'(TIMEOUT)) begin
                    state_d        = DONE;
                    mem_req_d      = 1'b0;
                    dout_d         = '0;
                    err_d          = 1'b1;
                    ack_d[grant_q] = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            rr_q       <= RR_INIT;
            pcnt_q     <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            mem_be_q   <= mem_be_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            pcnt_q     <= pcnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign ACK      = ack_q;
    assign ERR      = err_q;
    assign DOUT     = dout_q;
    assign MEM_REQ  = mem_req_q;
    assign MEM_ADDR = mem_addr_q;
    assign MEM_WE   = mem_we_q;
    assign MEM_DIN  = mem_din_q;
    assign MEM_BE   = mem_be_q;
    assign BUSY     = busy_q;
    assign GRANT    = grant_q;

endmodule

// File: doc/ram_req_arbiter.md
# ram_req_arbiter

Multi-requester arbiter that shares a single SDRAM-controller request port among `COUNT` clients (CPU mapper, VDP VRAM fetch, disk buffer, sound sample fetch). It sits between the clients and the SDRAM controller / UMA primary port. It serialises one transaction at a time using fixed-priority-with-limit plus round-robin selection. A watchdog timeout guarantees that no client ever hangs on a lost memory acknowledge.

## Interface
Parameters:
- `COUNT`, 4, number of requesters (2..8).
- `ADDR_WIDTH`, 23, word address width.
- `DATA_WIDTH`, 16, data width.
- `PRIO0`, 1, 1 = requester 0 has priority over round-robin; 0 = pure round-robin.
- `PRIO_LIMIT`, 4, max consecutive requester-0 grants while any other requester waits (1..15).
- `TIMEOUT`, 255, max cycles in WAIT before abort (1..1023).

Ports:
- `CLK` in 1: system clock (108 MHz); the block has a single clock.
- `RESET` in 1: synchronous, active-high reset.
- `REQ` in [COUNT-1:0]: per-client request level.
- `REQ_ADDR` in [COUNT-1:0][ADDR_WIDTH-1:0]: per-client address.
- `REQ_WE` in [COUNT-1:0]: 1 = write.
- `REQ_DIN` in [COUNT-1:0][DATA_WIDTH-1:0]: write data.
- `REQ_BE` in [COUNT-1:0][DATA_WIDTH/8-1:0]: byte enables.
- `ACK` out [COUNT-1:0]: one-cycle completion pulse.
- `ERR` out 1: valid with `ACK`; 1 = timed out.
- `DOUT` out DATA_WIDTH: read data, valid with `ACK`.
- `MEM_REQ` out 1: request to memory.
- `MEM_ADDR` out ADDR_WIDTH
- `MEM_WE` out 1
- `MEM_DIN` out DATA_WIDTH
- `MEM_BE` out DATA_WIDTH/8
- `MEM_ACK` in 1: one-cycle completion from memory.
- `MEM_DOUT` in DATA_WIDTH
- `BUSY` out 1: not in IDLE.
- `GRANT` out $clog2(COUNT): index of the current/last granted client.

## Operation
- The client holds `REQ[i]` and its address/data/BE stable until it samples `ACK[i]`=1. It drops `REQ` at that same edge.
- States: IDLE, WAIT, DONE.
- IDLE: if any `REQ` is set, select winner g:
  - If `PRIO0`, `REQ[0]`, and (prio_cnt < `PRIO_LIMIT` or no other REQ): g=0, prio_cnt++.
  - Otherwise, g = first set `REQ` scanning upward from `rr_ptr` (wrapping), excluding 0 when the limit blocks it. Then prio_cnt=0 and `rr_ptr` = (g+1) mod COUNT, skipping 0 when `PRIO0`.
  - prio_cnt resets to 0 whenever only requester 0 is requesting.
  - On selection: register the client's fields into `MEM_*`, set `MEM_REQ`=1, `GRANT`=g, go to WAIT.
- WAIT: hold `MEM_REQ` and the `MEM_*` fields.
  - On `MEM_ACK`: latch `MEM_DOUT` into `DOUT`, clear `MEM_REQ`, go to DONE with ERR=0.
  - If the watchdog reaches `TIMEOUT` first: clear `MEM_REQ`, set DOUT=0 and ERR=1, go to DONE.
- DONE: `ACK[GRANT]`=1 for exactly one cycle, then IDLE.
- `MEM_ACK` in IDLE or DONE is ignored. A late ACK after a timeout is discarded.
- `MEM_ACK` and watchdog expiry in the same cycle: the ACK wins (ERR=0, real data).

## Timing
- All outputs are registered.
- Reset values: `MEM_REQ`=0, `MEM_*`=0, `ACK`=0, `ERR`=0, `DOUT`=0, `BUSY`=0, `GRANT`=0, `rr_ptr`=0 (1 if `PRIO0`), prio_cnt=0, watchdog=0, state IDLE.
- Cycle map: REQ sampled at edge 0 → `MEM_REQ` high from cycle 1 → `MEM_ACK` at cycle k≥1 → `ACK` at cycle k+1 → IDLE at k+2. Request-to-ACK latency = memory latency + 2. Minimum issue spacing is 3 cycles.
- Watchdog: cleared on entry to WAIT, incremented each WAIT cycle. Abort occurs on the cycle the count equals `TIMEOUT`, so `ACK`/ERR appears at cycle `TIMEOUT`+2.
- `RESET` in any state: next edge returns to IDLE, `MEM_REQ`=0, and no `ACK` is issued for the aborted grant.
- Client input changes while not granted have no effect. Withdrawing `REQ` while granted is a protocol violation and the transaction still completes.

## Structure
- Package `ram_arb_pkg`:
  - state enum `arb_state_t` {IDLE, WAIT, DONE}.
  - `PRIO_CNT_W`=4.
  - function `wrap_inc(idx, count)`.
- Sub-module `ram_arb_rr_pick`: combinational rotate-priority encoder.
  - Inputs: `REQ` mask, `rr_ptr`.
  - Outputs: `VALID`, `IDX`.
  - Instantiated once; the requester-0 priority override and limit logic live in the parent.

## Test plan
- Reset: COUNT=4, all REQ=0 → all outputs 0, BUSY=0. Assert REQ[2] during RESET → no `MEM_REQ`.
- Single read: REQ[1], ADDR=0x00123, memory ACK 5 cycles after MEM_REQ with 0xBEEF → `MEM_ADDR`=0x00123, ACK[1] at cycle 7 with DOUT=0xBEEF, ERR=0.
- Round-robin, PRIO0=0: REQ[0..3] held and each re-raised one cycle after its ACK → grant order 0,1,2,3,0,1.
- Priority limit, PRIO0=1, PRIO_LIMIT=4: REQ[0] continuous, REQ[3] set → grants 0,0,0,0,3,0,0,0,0,3.
- Timeout, TIMEOUT=16: no `MEM_ACK` → ACK at cycle 18 with ERR=1 and DOUT=0. A late `MEM_ACK` in IDLE causes no output change.
- Simultaneous `MEM_ACK` and watchdog expiry → ERR=0, DOUT=MEM_DOUT. Reset asserted in WAIT → IDLE next edge, no ACK.
